// File: rtl/mem_dma.sv
// Block copy/fill engine in front of a single-port data memory.
// When idle, core accesses pass straight through. When busy, the engine drives the port.
module mem_dma #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 START,
    input  logic                 MODE,
    input  logic [ADDR_SIZE-1:0] SRC_ADDR,
    input  logic [ADDR_SIZE-1:0] DST_ADDR,
    input  logic [ADDR_SIZE:0]   LEN,
    input  logic [DATA_SIZE-1:0] FILL_DATA,
    output logic                 BUSY,
    output logic                 DONE,
    input  logic                 CPU_W,
    input  logic [DATA_SIZE-1:0] CPU_DATA_WR,
    input  logic [ADDR_SIZE-1:0] CPU_ADDR,
    output logic [DATA_SIZE-1:0] CPU_DATA_RD,
    output logic                 MEM_W,
    output logic [DATA_SIZE-1:0] MEM_WR_DATA,
    output logic [ADDR_SIZE-1:0] MEM_ADDR,
    input  logic [DATA_SIZE-1:0] MEM_RD_DATA
);

    localparam logic [ADDR_SIZE-1:0] AddrOne = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE:0]   CntOne  = (ADDR_SIZE + 1)'(1);

    typedef enum logic [2:0] {StIdle, StRd, StWr, StFill, StFin} state_e;

    state_e               state;
    logic [ADDR_SIZE-1:0] src_r;
    logic [ADDR_SIZE-1:0] dst_r;
    logic [DATA_SIZE-1:0] data_r;
    logic [DATA_SIZE-1:0] fill_r;
    logic [ADDR_SIZE:0]   cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            src_r  <= '0;
            dst_r  <= '0;
            data_r <= '0;
            fill_r <= '0;
            cnt_r  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (START) begin
                        src_r  <= SRC_ADDR;
                        dst_r  <= DST_ADDR;
                        cnt_r  <= LEN;
                        fill_r <= FILL_DATA;
                        if (LEN == '0)  state <= StFin;
                        else if (MODE)  state <= StFill;
                        else            state <= StRd;
                    end
                end
                StRd: begin
                    data_r <= MEM_RD_DATA;
                    src_r  <= src_r + AddrOne;
                    state  <= StWr;
                end
                StWr: begin
                    dst_r <= dst_r + AddrOne;
                    cnt_r <= cnt_r - CntOne;
                    state <= (cnt_r == CntOne) ? StFin : StRd;
                end
                StFill: begin
                    dst_r <= dst_r + AddrOne;
                    cnt_r <= cnt_r - CntOne;
                    state <= (cnt_r == CntOne) ? StFin : StFill;
                end
                StFin:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign BUSY        = (state != StIdle);
    assign DONE        = (state == StFin);
    assign CPU_DATA_RD = MEM_RD_DATA;

    // Engine writes are gated by rst so an abort never commits the word in flight.
    always_comb begin
        MEM_W       = 1'b0;
        MEM_WR_DATA = data_r;
        MEM_ADDR    = dst_r;
        case (state)
            StIdle: begin
                MEM_W       = CPU_W;
                MEM_WR_DATA = CPU_DATA_WR;
                MEM_ADDR    = CPU_ADDR;
            end
            StRd:   MEM_ADDR = src_r;
            StWr:   MEM_W = ~rst;
            StFill: begin
                MEM_W       = ~rst;
                MEM_WR_DATA = fill_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: attached 32x8 async-read memory, reference memory model
// and per-cycle port/timing checks.
module tb_mem_dma;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       START = 1'b0;
    logic       MODE = 1'b0;
    logic [4:0] SRC_ADDR = '0;
    logic [4:0] DST_ADDR = '0;
    logic [5:0] LEN = '0;
    logic [7:0] FILL_DATA = '0;
    logic       BUSY, DONE;
    logic       CPU_W = 1'b0;
    logic [7:0] CPU_DATA_WR = '0;
    logic [4:0] CPU_ADDR = '0;
    logic [7:0] CPU_DATA_RD;
    logic       MEM_W;
    logic [7:0] MEM_WR_DATA;
    logic [4:0] MEM_ADDR;
    logic [7:0] MEM_RD_DATA;

    mem_dma #(.DATA_SIZE(8), .ADDR_SIZE(5)) dut (
        .clk(clk), .rst(rst), .START(START), .MODE(MODE), .SRC_ADDR(SRC_ADDR),
        .DST_ADDR(DST_ADDR), .LEN(LEN), .FILL_DATA(FILL_DATA), .BUSY(BUSY), .DONE(DONE),
        .CPU_W(CPU_W), .CPU_DATA_WR(CPU_DATA_WR), .CPU_ADDR(CPU_ADDR),
        .CPU_DATA_RD(CPU_DATA_RD), .MEM_W(MEM_W), .MEM_WR_DATA(MEM_WR_DATA),
        .MEM_ADDR(MEM_ADDR), .MEM_RD_DATA(MEM_RD_DATA)
    );

    always #5 clk = ~clk;

    // Attached data memory
    logic [7:0] mem [32];
    logic       init_mem = 1'b1;
    assign MEM_RD_DATA = mem[MEM_ADDR];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
        end else if (MEM_W) begin
            mem[MEM_ADDR] <= MEM_WR_DATA;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Reference model: expected memory and the planned transfer
    logic [7:0] ref_mem [32];
    bit         active = 1'b0;
    bit         checking = 1'b0;
    bit         m_mode;
    int         m_len, t_start, total, abort_k;
    int         w_addr [33];
    int         w_data [33];
    int         done_k = -1;
    int         wcount = 0;
    localparam int NoAbort = 1000000;

    task automatic start_xfer(input bit mode, input int src, input int dst, input int len,
                              input logic [7:0] fill, input int abrt);
        int committed;
        int v;
        @(posedge clk); #1;
        START = 1'b1; MODE = mode; SRC_ADDR = src[4:0]; DST_ADDR = dst[4:0];
        LEN = len[5:0]; FILL_DATA = fill;
        t_start = cyc; m_mode = mode; m_len = len; abort_k = abrt;
        done_k = -1; wcount = 0;
        total = (len == 0) ? 1 : (mode ? len + 1 : 2 * len + 1);
        committed = len;
        if (mode && abrt - 1 < len) committed = abrt - 1;
        for (int i = 0; i < len; i++) begin
            v = mode ? int'(fill) : int'(ref_mem[(src + i) % 32]);
            w_addr[i] = (dst + i) % 32;
            w_data[i] = v;
            if (i < committed) ref_mem[(dst + i) % 32] = 8'(v);
        end
        active = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp_mem(input string nm);
        for (int i = 0; i < 32; i++) check(nm, mem[i], ref_mem[i]);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin : cmp
        int k, idx;
        bit in_win, is_w;
        if (checking) begin
            k = cyc - t_start;
            in_win = active && k >= 1 && k <= total && k <= abort_k;
            is_w = 1'b0;
            idx = 0;
            if (in_win && m_len > 0 && k < abort_k) begin
                if (m_mode) begin
                    is_w = (k <= m_len);
                    idx = k - 1;
                end else begin
                    is_w = (k % 2 == 0);
                    idx = k / 2 - 1;
                end
            end
            check("busy", BUSY, in_win);
            check("done", DONE, in_win && k == total);
            if (DONE === 1'b1) done_k = k;
            if (in_win) begin
                check("eng_w", MEM_W, is_w);
                if (is_w) begin
                    check("eng_addr", MEM_ADDR, w_addr[idx]);
                    check("eng_data", MEM_WR_DATA, w_data[idx]);
                end
                if (MEM_W === 1'b1) wcount++;
            end else begin
                check("pass_w", MEM_W, CPU_W);
                check("pass_addr", MEM_ADDR, CPU_ADDR);
                if (CPU_W) check("pass_data", MEM_WR_DATA, CPU_DATA_WR);
                check("cpu_rd", CPU_DATA_RD, mem[CPU_ADDR]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i);
        abort_k = NoAbort;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        init_mem = 1'b0;
        checking = 1'b1;

        // Copy 0..3 -> 16..19
        start_xfer(1'b0, 0, 16, 4, 8'h00, NoAbort);
        wait_cycles(11);
        check("copy_done_k", done_k, 9);
        check("copy_wcount", wcount, 4);
        for (int i = 0; i < 4; i++) check("copy_word", mem[16 + i], i);
        cmp_mem("copy_mem");

        // Passthrough write then read
        @(posedge clk); #1;
        CPU_W = 1'b1; CPU_ADDR = 5'd3; CPU_DATA_WR = 8'hA5;
        ref_mem[3] = 8'hA5;
        @(posedge clk); #1;
        CPU_W = 1'b0;
        @(negedge clk);
        check("pass_rd", CPU_DATA_RD, 8'hA5);
        check("pass_busy", BUSY, 1'b0);

        // Fill with wrap at the top address
        start_xfer(1'b1, 0, 30, 4, 8'h5C, NoAbort);
        wait_cycles(7);
        check("fill_done_k", done_k, 5);
        check("fill_30", mem[30], 8'h5C);
        check("fill_31", mem[31], 8'h5C);
        check("fill_0", mem[0], 8'h5C);
        check("fill_1", mem[1], 8'h5C);
        check("fill_2", mem[2], 8'd2);
        cmp_mem("fill_mem");

        // LEN = 0
        start_xfer(1'b0, 5, 9, 0, 8'h00, NoAbort);
        wait_cycles(4);
        check("len0_done_k", done_k, 1);
        check("len0_wcount", wcount, 0);
        cmp_mem("len0_mem");

        // Contention: core write and extra STARTs during a copy
        start_xfer(1'b0, 4, 24, 4, 8'h00, NoAbort);
        CPU_W = 1'b1; CPU_ADDR = 5'd20; CPU_DATA_WR = 8'h77;
        wait_cycles(2);
        START = 1'b1; MODE = 1'b1; DST_ADDR = 5'd20; LEN = 6'd2; FILL_DATA = 8'hEE;
        wait_cycles(1);
        START = 1'b0;
        wait_cycles(5);
        START = 1'b1;
        wait_cycles(1);
        START = 1'b0; CPU_W = 1'b0;
        wait_cycles(3);
        check("cont_done_k", done_k, 9);
        check("cont_wcount", wcount, 4);
        check("cont_mem20", mem[20], 8'd20);
        check("cont_mem24", mem[24], 8'd4);
        check("cont_mem27", mem[27], 8'd7);
        cmp_mem("cont_mem");

        // Reset in cycle 4 of an 8-word fill
        start_xfer(1'b1, 0, 8, 8, 8'h11, 4);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", BUSY, 1'b0);
        wait_cycles(3);
        check("abort_done_k", done_k, -1);
        check("abort_wcount", wcount, 3);
        check("abort_mem8", mem[8], 8'h11);
        check("abort_mem10", mem[10], 8'h11);
        check("abort_mem11", mem[11], 8'd11);
        check("abort_mem15", mem[15], 8'd15);
        cmp_mem("abort_mem");

        // Full-depth fill
        start_xfer(1'b1, 0, 0, 32, 8'hFF, NoAbort);
        wait_cycles(35);
        check("full_done_k", done_k, 33);
        check("full_wcount", wcount, 32);
        check("full_mem0", mem[0], 8'hFF);
        check("full_mem31", mem[31], 8'hFF);
        cmp_mem("full_mem");

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
